// File: rtl/soc_ctrl_rst_seq_gen_if.sv
// Signal bundle between the reset sequencer and whoever drives it:
// per-channel delay, clock-enable and soft-reset requests in, and
// per-channel resets, gated enables and status flags out.
interface soc_ctrl_rst_seq_gen_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
) ();

   logic [NUM_CH*CNT_W-1:0] delay_i;
   logic [NUM_CH-1:0]       clk_en_i;
   logic [NUM_CH-1:0]       sw_rst_req_i;
   logic [NUM_CH-1:0]       arst_no;
   logic [NUM_CH-1:0]       clk_en_o;
   logic                    busy_o;
   logic                    done_o;

   // Requester side: drives delays and requests, observes resets and status
   modport master (
      output delay_i, clk_en_i, sw_rst_req_i,
      input  arst_no, clk_en_o, busy_o, done_o
   );

   // Sequencer side
   modport slave (
      input  delay_i, clk_en_i, sw_rst_req_i,
      output arst_no, clk_en_o, busy_o, done_o
   );

endinterface

// File: rtl/soc_ctrl_rst_seq_gen.sv
// Power-on reset / clock-enable sequencer for NUM_CH channels.
// After reset each channel is released once its delay has elapsed, either
// one after another (PAR_MODE=0) or all at once (PAR_MODE=1). Once the
// power-on sequence is complete, per-channel soft resets are queued and
// served lowest index first, reusing the same delay counters.
module soc_ctrl_rst_seq_gen #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 8,
   parameter int PAR_MODE = 0
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   soc_ctrl_rst_seq_gen_if.slave bus
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_SEQ,
      ST_DONE,
      ST_SWRST
   } state_e;

   state_e                        state_q, state_d;
   logic [IDX_W-1:0]              idx_q, idx_d;      // channel served in SWRST
   logic                          done_q, done_d;
   logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;      // remaining delay per channel
   logic [NUM_CH-1:0]             act_q, act_d;      // channel is counting
   logic [NUM_CH-1:0]             rst_q, rst_d;      // registered arst_no
   logic [NUM_CH-1:0]             en_q, en_d;        // released-enable flag
   logic [NUM_CH-1:0]             pend_q, pend_d;    // queued soft resets

   logic [NUM_CH-1:0]             rel_w;             // channel releases this edge
   logic [NUM_CH-1:0]             start_w;           // channel activates this edge
   logic [NUM_CH-1:0]             clr_w;             // drop reset and enable now
   logic [NUM_CH-1:0]             pend_clr;
   logic [NUM_CH-1:0]             req_all;
   logic [IDX_W-1:0]              low_idx;

   // Next-state, activation and per-channel counter logic
   // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      done_d   = done_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      act_d    = act_q;
      rst_d    = rst_q;
      en_d     = en_q;
      start_w  = '0;
      clr_w    = '0;
      pend_clr = '0;
      rel_w    = '0;
      req_all  = pend_q | bus.sw_rst_req_i;
      low_idx  = '0;

      // Scan from the top so the lowest requesting channel wins
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (req_all[k]) low_idx = IDX_W'(k);
      end

      // A counting channel releases on the edge after its count hits zero;
      // counting down from the sampled value means a full-scale delay never wraps
      for (int k = 0; k < NUM_CH; k++) begin
         rel_w[k] = act_q[k] && (cnt_q[k] == '0);
      end

      case (state_q)
         ST_INIT: begin
            state_d = ST_SEQ;
            if (PAR_MODE != 0) start_w = '1;
            else               start_w[0] = 1'b1;
         end

         ST_SEQ: begin
            // Sequential mode: the next channel activates on the release edge
            if (PAR_MODE == 0) begin
               for (int k = 0; k < NUM_CH - 1; k++) begin
                  start_w[k+1] = rel_w[k];
               end
            end
            if (&rst_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end

         ST_DONE: begin
            pend_d = req_all;
            if (|req_all) begin
               state_d          = ST_SWRST;
               idx_d            = low_idx;
               start_w[low_idx] = 1'b1;
               clr_w[low_idx]   = 1'b1;
            end
         end

         ST_SWRST: begin
            if (rel_w[idx_q]) begin
               state_d         = ST_DONE;
               pend_clr[idx_q] = 1'b1;
            end
            // New requests are ORed in after the clear so a repeat request
            // for the channel being served is queued again
            pend_d = (pend_q & ~pend_clr) | bus.sw_rst_req_i;
         end

         default: state_d = ST_INIT;
      endcase

      for (int k = 0; k < NUM_CH; k++) begin
         if (start_w[k]) begin
            cnt_d[k] = bus.delay_i[k*CNT_W +: CNT_W];
            act_d[k] = 1'b1;
         end else if (rel_w[k]) begin
            act_d[k] = 1'b0;
         end else if (act_q[k]) begin
            cnt_d[k] = cnt_q[k] - 1'b1;
         end
         rst_d[k] = clr_w[k] ? 1'b0 : (rst_q[k] | rel_w[k]);
         // Enable flag follows the registered reset one edge later
         en_d[k]  = clr_w[k] ? 1'b0 : rst_q[k];
      end
   end

   // State and channel registers; reset aborts any sequence asynchronously
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= ST_INIT;
         idx_q   <= '0;
         done_q  <= 1'b0;
         // NOTE: the counter array is small and must read zero after reset, so it is reset like any other flop.
         cnt_q   <= '0;
         act_q   <= '0;
         rst_q   <= '0;
         en_q    <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         rst_q   <= rst_d;
         en_q    <= en_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.arst_no  = rst_q;
   assign bus.clk_en_o = bus.clk_en_i & en_q;
   assign bus.busy_o   = (state_q == ST_SEQ) || (state_q == ST_SWRST) || (|pend_q);
   assign bus.done_o   = done_q;

endmodule

// File: tb/tb_soc_ctrl_rst_seq_gen.sv
// Directed bench for the reset sequencer: one sequential and one parallel
// instance share clock and reset and receive the same delays.
module tb_soc_ctrl_rst_seq_gen;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   logic clk_i   = 1'b0;
   logic arst_ni = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;

   // Hand-computed release edges for D = {3,0,5,2}
   int rel_seq [4] = '{5, 6, 12, 15};
   int en_seq  [4] = '{6, 7, 13, 16};
   int rel_par [4] = '{5, 2, 7, 4};
   int en_par  [4] = '{6, 3, 8, 5};

   // Soft-reset windows, offsets 0..7 after the request edge E
   logic [3:0] sw_seq_rst [8] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011,
                                  4'b1011, 4'b1011, 4'b1111, 4'b1111};
   logic [3:0] sw_seq_en  [8] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011,
                                  4'b1011, 4'b1011, 4'b1011, 4'b1111};
   logic       sw_seq_bsy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [3:0] sw_par_rst [8] = '{4'b1101, 4'b1111, 4'b0111, 4'b0111,
                                  4'b0111, 4'b1111, 4'b1111, 4'b1111};
   logic [3:0] sw_par_en  [8] = '{4'b1101, 4'b1101, 4'b0111, 4'b0111,
                                  4'b0111, 4'b0111, 4'b1111, 4'b1111};
   logic       sw_par_bsy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   soc_ctrl_rst_seq_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) seq_if ();
   soc_ctrl_rst_seq_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) par_if ();

   soc_ctrl_rst_seq_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PAR_MODE(0)) u_seq (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .bus     (seq_if.slave)
   );

   soc_ctrl_rst_seq_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PAR_MODE(1)) u_par (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .bus     (par_if.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (edge %0d): got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
      end
   endtask

   // Advance to 1ns after the next rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
      edge_n++;
   endtask

   function automatic logic [3:0] after_edge(input int rel [4], input int e);
      logic [3:0] v;
      for (int k = 0; k < 4; k++) v[k] = (e >= rel[k]);
      return v;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, " seq arst_no"},  32'(seq_if.arst_no),  32'h0);
      check({tag, " seq clk_en_o"}, 32'(seq_if.clk_en_o), 32'h0);
      check({tag, " seq busy_o"},   32'(seq_if.busy_o),   32'h0);
      check({tag, " seq done_o"},   32'(seq_if.done_o),   32'h0);
      check({tag, " par arst_no"},  32'(par_if.arst_no),  32'h0);
      check({tag, " par clk_en_o"}, 32'(par_if.clk_en_o), 32'h0);
      check({tag, " par busy_o"},   32'(par_if.busy_o),   32'h0);
      check({tag, " par done_o"},   32'(par_if.done_o),   32'h0);
   endtask

   task automatic set_delays(input logic [7:0] d0);
      seq_if.delay_i = {8'd2, 8'd5, 8'd0, d0};
      par_if.delay_i = {8'd2, 8'd5, 8'd0, d0};
   endtask

   // Power-on sequence from edge 1 to last_e; D_0 is changed and soft resets
   // are requested mid-sequence, and neither may have any effect
   task automatic power_on(input int last_e);
      for (int e = 1; e <= last_e; e++) begin
         tick();
         if (e == 2) set_delays(8'd0);
         if (e == 3) begin
            seq_if.sw_rst_req_i = 4'hF;
            par_if.sw_rst_req_i = 4'hF;
         end
         if (e == 4) begin
            seq_if.sw_rst_req_i = 4'h0;
            par_if.sw_rst_req_i = 4'h0;
         end
         check("seq arst_no",  32'(seq_if.arst_no),  32'(after_edge(rel_seq, e)));
         check("seq clk_en_o", 32'(seq_if.clk_en_o), 32'(after_edge(en_seq, e)));
         check("seq done_o",   32'(seq_if.done_o),   32'(e >= 16));
         check("seq busy_o",   32'(seq_if.busy_o),   32'(e <= 15));
         check("par arst_no",  32'(par_if.arst_no),  32'(after_edge(rel_par, e)));
         check("par clk_en_o", 32'(par_if.clk_en_o), 32'(after_edge(en_par, e)));
         check("par done_o",   32'(par_if.done_o),   32'(e >= 8));
         check("par busy_o",   32'(par_if.busy_o),   32'(e <= 7));
      end
      set_delays(8'd3);
   endtask

   initial begin
      seq_if.clk_en_i     = 4'hF;
      par_if.clk_en_i     = 4'hF;
      seq_if.sw_rst_req_i = 4'h0;
      par_if.sw_rst_req_i = 4'h0;
      set_delays(8'd3);

      // Held in reset across two clock edges
      #23;
      check_all_zero("in reset");
      @(negedge clk_i);
      arst_ni = 1'b1;
      edge_n  = 0;

      // Start the sequence, then abort it asynchronously at edge 10
      power_on(10);
      arst_ni = 1'b0;
      #1;
      check_all_zero("async abort");
      edge_n = 0;
      #99;
      arst_ni = 1'b1;

      // Full sequence again relative to the new edge 1
      power_on(17);

      // Soft resets: channel 2 on the sequential instance, channels 1 and 3 on
      // the parallel one, all requested at edge E = 20
      tick();
      tick();
      seq_if.sw_rst_req_i = 4'b0100;
      par_if.sw_rst_req_i = 4'b1010;
      for (int off = 0; off < 8; off++) begin
         tick();
         if (off == 0) begin
            seq_if.sw_rst_req_i = 4'h0;
            par_if.sw_rst_req_i = 4'h0;
         end
         check("swrst seq arst_no",  32'(seq_if.arst_no),  32'(sw_seq_rst[off]));
         check("swrst seq clk_en_o", 32'(seq_if.clk_en_o), 32'(sw_seq_en[off]));
         check("swrst seq busy_o",   32'(seq_if.busy_o),   32'(sw_seq_bsy[off]));
         check("swrst seq done_o",   32'(seq_if.done_o),   32'h1);
         check("swrst par arst_no",  32'(par_if.arst_no),  32'(sw_par_rst[off]));
         check("swrst par clk_en_o", 32'(par_if.clk_en_o), 32'(sw_par_en[off]));
         check("swrst par busy_o",   32'(par_if.busy_o),   32'(sw_par_bsy[off]));
      end

      // Full-scale delay on channel 0 must not release early through a wrap
      arst_ni = 1'b0;
      set_delays(8'd255);
      #20;
      @(negedge clk_i);
      arst_ni = 1'b1;
      edge_n  = 0;
      for (int e = 1; e <= 256; e++) tick();
      check("max delay seq ch0 before", 32'(seq_if.arst_no[0]), 32'h0);
      check("max delay par ch0 before", 32'(par_if.arst_no[0]), 32'h0);
      tick();
      check("max delay seq ch0 release", 32'(seq_if.arst_no[0]), 32'h1);
      check("max delay par ch0 release", 32'(par_if.arst_no[0]), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/soc_ctrl_rst_seq_gen.md
SOC_CTRL_RST_SEQ_GEN -- requirements
Module: soc_ctrl_rst_seq_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of reset/clock-enable channels, range 1..16.
REQ-002 SHALL have parameter CNT_W, default 8: width of each per-channel delay field.
REQ-003 SHALL have parameter PAR_MODE, default 0: 0 releases channels sequentially, 1 releases them in parallel.
REQ-004 SHALL have a single clock and an asynchronous active-low reset.
REQ-005 clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 arst_ni  in  1  asynchronous active-low reset.
REQ-007 delay_i  in  NUM_CH*CNT_W  per-channel release delay D_k, field k at bits [k*CNT_W +: CNT_W].
REQ-008 clk_en_i  in  NUM_CH  per-channel functional clock-enable request.
REQ-009 sw_rst_req_i  in  NUM_CH  per-channel soft-reset request; single-cycle pulse per bit.
REQ-010 arst_no  out  NUM_CH  per-channel active-low reset, registered.
REQ-011 clk_en_o  out  NUM_CH  per-channel gated clock enable.
REQ-012 busy_o  out  1  high while any channel is counting or a soft reset is pending.
REQ-013 done_o  out  1  high once the power-on sequence has completed.

Function
REQ-014 Edge numbering: edge 1 is the first rising edge of clk_i with arst_ni high.
REQ-015 Each channel SHALL have an activation edge A_k; D_k is sampled at A_k; later delay_i changes SHALL NOT affect a running count.
REQ-016 arst_no[k] SHALL rise at edge A_k+D_k+1; D_k=0 gives release one edge after activation; D_k=2^CNT_W-1 SHALL NOT wrap.
REQ-017 A released-enable flag for channel k SHALL set one edge after arst_no[k] rises; clk_en_o[k] = clk_en_i[k] AND flag, combinational from the flag register.
REQ-018 FSM states SHALL be: INIT, SEQ, DONE, SWRST.
REQ-019 INIT: entered on reset; moves to SEQ at edge 1; the channel index is 0.
REQ-020 SEQ, PAR_MODE=0: A_0=1; A_{k+1} equals the release edge of channel k.
REQ-021 SEQ, PAR_MODE=1: all A_k=1, with an independent counter per channel.
REQ-022 The FSM SHALL leave SEQ for DONE one edge after the last channel releases; done_o SHALL rise on that edge and stay high until arst_ni asserts.
REQ-023 In INIT and SEQ, sw_rst_req_i SHALL be ignored and not latched.
REQ-024 In DONE, a sampled sw_rst_req_i[k] SHALL set pending bit k.
REQ-025 On each DONE cycle with pending bits set, the lowest set index j SHALL be served by entering SWRST with A_j equal to the current edge.
REQ-026 On entering SWRST, arst_no[j] and the flag for j SHALL clear on the same edge, so clk_en_o[j] drops with the reset.
REQ-027 SWRST releases j per REQ-016 and REQ-017, clears pending[j], and returns to DONE.
REQ-028 Requests arriving during SWRST SHALL be latched; a repeat request for the channel being served SHALL be latched and served again afterwards.
REQ-029 Channels not being served SHALL keep their outputs unchanged.
REQ-030 busy_o = (state is SEQ) OR (state is SWRST) OR (any pending bit set).

Reset
REQ-031 While arst_ni is low: arst_no=0, clk_en_o=0, busy_o=0, done_o=0, pending=0, counters=0, state=INIT.
REQ-032 arst_ni assertion mid-sequence or mid-SWRST SHALL abort immediately and asynchronously; the sequence restarts from channel 0 after release.

Verification
REQ-033 NUM_CH=4, D={3,0,5,2}, PAR_MODE=0, clk_en_i=4'hF -> arst_no bits rise at edges 5,6,12,15; clk_en_o bits at 6,7,13,16; done_o at 16.
REQ-034 Same delays, PAR_MODE=1 -> arst_no bits rise at edges 5,2,7,4; done_o at 8.
REQ-035 After done, sw_rst_req_i=4'b0100 sampled at edge E -> arst_no[2] and clk_en_o[2] low after E; arst_no[2] high at E+6; clk_en_o[2] high at E+7; other channels constant.
REQ-036 After done, sw_rst_req_i=4'b1010 in one cycle at edge E -> channel 1 released at E+1; channel 3 served next and released at E+1+1+3; busy_o low afterwards.
REQ-037 arst_ni pulsed low for 100ns at edge 10 of the REQ-033 scenario -> all outputs 0 immediately; after release the full REQ-033 timing repeats relative to the new edge 1.
REQ-038 D_0=255, CNT_W=8 -> arst_no[0] rises at edge 257, with no early release from counter wrap.
